execute_stage: RTL and testbench
================================

# execute_stage

Registered execute stage for the ARMv8 (LEGv8) processor. It sits directly downstream of the decode stage and consumes `read_data1`, `read_data2`, `ext_addr`, `cur_pc`, the decoded control bits and the instruction opcode field. It produces the ALU result, zero flag, branch target and branch decision for the memory/writeback stage and the fetch PC mux. Most operations complete in one cycle. `MUL` uses an iterative shift-add engine with a valid/ready handshake that stalls upstream.

## Interface
- `WORD`, 64, datapath width (matches `` `WORD `` from definitions.vh)
- `clk` in 1, single clock, all state updates on rising edge
- `reset` in 1, synchronous, active-low (0 = reset)
- `in_valid` in 1, decode offers an instruction
- `in_ready` out 1, stage accepts this cycle
- `cur_pc` in WORD, PC of offered instruction
- `read_data1`, `read_data2` in WORD, register operands
- `ext_addr` in WORD, sign-extended immediate/offset
- `opcode` in 11, instruction[31:21]
- `alu_op` in 2, `alu_src`/`branch`/`uncondbranch`/`mem_read`/`mem_write`/`mem_to_reg` in 1 each, from control unit
- `write_reg` in 5, destination register
- `out_valid` out 1, result registers hold a valid instruction
- `out_ready` in 1, downstream consumes this cycle
- `alu_result` out WORD; `zero` out 1; `branch_target` out WORD; `pc_src` out 1
- `store_data` out WORD (registered `read_data2`); `mem_read_o`/`mem_write_o`/`mem_to_reg_o` out 1; `write_reg_o` out 5

## Operation
- Operand B = `alu_src` ? `ext_addr` : `read_data2`.
- ALU function:
  - `alu_op` 00: ADD (load/store address).
  - `alu_op` 01: pass B (CBZ test).
  - `alu_op` 10: decode by `opcode`: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR, 10011011000 MUL.
  - Other opcodes: result 0.
  - `alu_op` 11: result 0.
- Arithmetic is modulo 2^WORD. No carry or overflow outputs.
- `zero` = (`alu_result` == 0).
- `branch_target` = `cur_pc` + (`ext_addr` << 2), truncated to WORD.
- `pc_src` = `uncondbranch` | (`branch` & `zero`).
- Accept: `in_ready` & `in_valid`. `in_ready` = (state == IDLE) & (!`out_valid` | `out_ready`).
- FSM states:
  - IDLE: on accept of a non-MUL instruction, load all outputs and set `out_valid`; stay IDLE. On accept of MUL, latch A, B and the pass-through controls; clear the accumulator and iteration counter; go to MUL_BUSY.
  - MUL_BUSY: each cycle, if B[0] then acc += A; A <<= 1; B >>= 1; count++. After WORD iterations (count == WORD-1 on the current cycle), go to MUL_DONE.
  - MUL_DONE: when !`out_valid` | `out_ready`, load `alu_result` = acc (low WORD bits), `zero`, and controls; set `out_valid`; go to IDLE.
- `out_valid` clears on `out_ready` unless a new result loads the same cycle.
- Output registers hold their value while `out_valid` & !`out_ready`.

## Timing
- Reset (`reset` == 0 at a rising edge):
  - State returns to IDLE and the counter to 0.
  - All outputs go to 0, including `out_valid`, `pc_src` and `zero`.
  - `in_ready` reads 0 during reset and 1 on the first cycle after.
- Non-MUL latency: accepted at edge N, outputs valid after edge N. Throughput is 1 per cycle when `out_ready` = 1.
- MUL latency:
  - Accepted at edge N, `out_valid` rises after edge N+WORD+1 (65 cycles for WORD = 64).
  - `in_ready` = 0 from edge N until the MUL result loads.
  - `out_valid` does not rise before edge N+WORD+1, even if B becomes 0 early.
- Backpressure: with `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0. No input is accepted and outputs stay stable.
- Simultaneous `out_ready` and accept: the old result retires and the new result loads on the same edge, so `out_valid` stays 1.
- Reset mid-MUL: the operation is discarded, no `out_valid` pulse follows, and the stage is back in IDLE the next cycle.
- Inputs are sampled only on accept. Upstream changes while `in_ready` = 0 have no effect.

## Test plan
- ADD: x=20, y=10, `alu_op`=10, opcode ADD -> next cycle `alu_result`=30, `zero`=0, `out_valid`=1.
- SUB: 30-30 -> `alu_result`=0, `zero`=1. With `branch`=0 -> `pc_src`=0.
- CBZ: `alu_op`=01, `read_data2`=0, `branch`=1, `cur_pc`=0x10, `ext_addr`=3 -> `branch_target`=0x1C, `pc_src`=1. Repeat with `read_data2`=5 -> `pc_src`=0.
- MUL: 7×6 -> `in_ready` low for 65 cycles, then `alu_result`=42. Also 0xFFFF_FFFF_FFFF_FFFF × 2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: `out_ready`=0 after an ORR (0x1E | 0x10) -> `alu_result`=0x1E held and `in_ready`=0. Then raise `out_ready` with the next ADD valid -> `out_valid` stays 1 and the result updates.
- Reset: assert `reset`=0 at cycle 20 of a MUL -> all outputs 0 the next cycle, no later `out_valid`, and `in_ready`=1 one cycle after release.

Source files
------------

// File: rtl/execute_if.sv
// Execute stage bus: decode-side offer (in_*), control bits, and the
// registered result bundle handed to the memory/writeback stage.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The payload is only meaningful while valid is 1; ready may
// depend combinationally on the receiver's state but never on valid.
interface execute_if #(
  parameter int WORD = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] cur_pc;
  logic [WORD-1:0] read_data1;
  logic [WORD-1:0] read_data2;
  logic [WORD-1:0] ext_addr;
  logic [10:0]     opcode;
  logic [1:0]      alu_op;
  logic            alu_src;
  logic            branch;
  logic            uncondbranch;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic [4:0]      write_reg;

  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] alu_result;
  logic            zero;
  logic [WORD-1:0] branch_target;
  logic            pc_src;
  logic [WORD-1:0] store_data;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_to_reg_o;
  logic [4:0]      write_reg_o;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, cur_pc, read_data1, read_data2, ext_addr, opcode, alu_op,
           alu_src, branch, uncondbranch, mem_read, mem_write, mem_to_reg,
           write_reg, out_ready,
    input  in_ready, out_valid, alu_result, zero, branch_target, pc_src,
           store_data, mem_read_o, mem_write_o, mem_to_reg_o, write_reg_o
  );

  // Execute stage side.
  modport slave (
    input  in_valid, cur_pc, read_data1, read_data2, ext_addr, opcode, alu_op,
           alu_src, branch, uncondbranch, mem_read, mem_write, mem_to_reg,
           write_reg, out_ready,
    output in_ready, out_valid, alu_result, zero, branch_target, pc_src,
           store_data, mem_read_o, mem_write_o, mem_to_reg_o, write_reg_o
  );
endinterface

// File: rtl/execute_stage.sv
// LEGv8 registered execute stage. Single-cycle ALU ops load the output
// registers on accept; MUL runs a fixed WORD-iteration shift-add loop and
// stalls upstream until its result has been loaded.
module execute_stage #(
  parameter int WORD = 64
) (
  input  logic       clk,
  input  logic       reset,
  execute_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(WORD);

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WORD-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;

  // Side information captured when a MUL is accepted, replayed at load time.
  logic [WORD-1:0] m_bt_q, m_bt_d, m_sd_q, m_sd_d;
  logic            m_br_q, m_br_d, m_ub_q, m_ub_d;
  logic            m_mr_q, m_mr_d, m_mw_q, m_mw_d, m_m2r_q, m_m2r_d;
  logic [4:0]      m_wr_q, m_wr_d;

  // Output registers.
  logic [WORD-1:0] res_q, res_d, bt_q, bt_d, sd_q, sd_d;
  logic            zero_q, zero_d, pcs_q, pcs_d, ov_q, ov_d;
  logic            mr_q, mr_d, mw_q, mw_d, m2r_q, m2r_d;
  logic [4:0]      wr_q, wr_d;

  logic [WORD-1:0] op_b, alu_res, bt_new;
  logic            is_mul, sink_free, in_ready, accept;

  assign op_b      = bus.alu_src ? bus.ext_addr : bus.read_data2;
  assign is_mul    = (bus.alu_op == 2'b10) && (bus.opcode == OP_MUL);
  assign bt_new    = bus.cur_pc + (bus.ext_addr << 2);
  assign sink_free = !ov_q || bus.out_ready;
  // Gated by reset so upstream never sees a ready while the stage is held.
  assign in_ready  = reset && (state_q == IDLE) && sink_free;
  assign accept    = bus.in_valid && in_ready;

  // Single-cycle ALU result for the offered instruction.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      2'b00: alu_res = bus.read_data1 + op_b;
      2'b01: alu_res = op_b;
      2'b10: begin
        case (bus.opcode)
          OP_ADD:  alu_res = bus.read_data1 + op_b;
          OP_SUB:  alu_res = bus.read_data1 - op_b;
          OP_AND:  alu_res = bus.read_data1 & op_b;
          OP_ORR:  alu_res = bus.read_data1 | op_b;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Next-state, multiplier datapath and output-register loading.
  always_comb begin
    state_d = state_q;  cnt_d  = cnt_q;
    a_d     = a_q;      b_d    = b_q;    acc_d = acc_q;
    m_bt_d  = m_bt_q;   m_sd_d = m_sd_q; m_br_d = m_br_q; m_ub_d = m_ub_q;
    m_mr_d  = m_mr_q;   m_mw_d = m_mw_q; m_m2r_d = m_m2r_q; m_wr_d = m_wr_q;
    res_d   = res_q;    bt_d   = bt_q;   sd_d = sd_q;
    zero_d  = zero_q;   pcs_d  = pcs_q;
    mr_d    = mr_q;     mw_d   = mw_q;   m2r_d = m2r_q;  wr_d = wr_q;
    ov_d    = ov_q && !bus.out_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            a_d     = bus.read_data1;
            b_d     = op_b;
            acc_d   = '0;
            cnt_d   = '0;
            m_bt_d  = bt_new;
            m_sd_d  = bus.read_data2;
            m_br_d  = bus.branch;
            m_ub_d  = bus.uncondbranch;
            m_mr_d  = bus.mem_read;
            m_mw_d  = bus.mem_write;
            m_m2r_d = bus.mem_to_reg;
            m_wr_d  = bus.write_reg;
            state_d = MUL_BUSY;
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            pcs_d  = bus.uncondbranch || (bus.branch && (alu_res == '0));
            bt_d   = bt_new;
            sd_d   = bus.read_data2;
            mr_d   = bus.mem_read;
            mw_d   = bus.mem_write;
            m2r_d  = bus.mem_to_reg;
            wr_d   = bus.write_reg;
            ov_d   = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        // Always runs the full WORD iterations so latency is data-independent.
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WORD - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (sink_free) begin
          res_d   = acc_q;
          zero_d  = (acc_q == '0);
          pcs_d   = m_ub_q || (m_br_q && (acc_q == '0));
          bt_d    = m_bt_q;
          sd_d    = m_sd_q;
          mr_d    = m_mr_q;
          mw_d    = m_mw_q;
          m2r_d   = m_m2r_q;
          wr_d    = m_wr_q;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;  cnt_q <= '0;
      a_q <= '0;  b_q <= '0;  acc_q <= '0;
      m_bt_q <= '0;  m_sd_q <= '0;  m_br_q <= 1'b0;  m_ub_q <= 1'b0;
      m_mr_q <= 1'b0;  m_mw_q <= 1'b0;  m_m2r_q <= 1'b0;  m_wr_q <= '0;
      res_q <= '0;  bt_q <= '0;  sd_q <= '0;
      zero_q <= 1'b0;  pcs_q <= 1'b0;  ov_q <= 1'b0;
      mr_q <= 1'b0;  mw_q <= 1'b0;  m2r_q <= 1'b0;  wr_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;
      a_q <= a_d;  b_q <= b_d;  acc_q <= acc_d;
      m_bt_q <= m_bt_d;  m_sd_q <= m_sd_d;  m_br_q <= m_br_d;  m_ub_q <= m_ub_d;
      m_mr_q <= m_mr_d;  m_mw_q <= m_mw_d;  m_m2r_q <= m_m2r_d;  m_wr_q <= m_wr_d;
      res_q <= res_d;  bt_q <= bt_d;  sd_q <= sd_d;
      zero_q <= zero_d;  pcs_q <= pcs_d;  ov_q <= ov_d;
      mr_q <= mr_d;  mw_q <= mw_d;  m2r_q <= m2r_d;  wr_q <= wr_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = ov_q;
  assign bus.alu_result    = res_q;
  assign bus.zero          = zero_q;
  assign bus.branch_target = bt_q;
  assign bus.pc_src        = pcs_q;
  assign bus.store_data    = sd_q;
  assign bus.mem_read_o    = mr_q;
  assign bus.mem_write_o   = mw_q;
  assign bus.mem_to_reg_o  = m2r_q;
  assign bus.write_reg_o   = wr_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases for the ALU, branch, MUL timing,
// backpressure and reset, then randomized traffic against a reference model.
module tb_execute_stage;
  localparam int WORD  = 64;
  localparam int REC_W = 202;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  execute_if #(.WORD(WORD)) bus ();

  execute_stage #(.WORD(WORD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: record = {result, target, store, zero, pc_src, mr, mw, m2r, wr}
  function automatic logic [REC_W-1:0] model(
    input logic [63:0] rd1, rd2, ext, pc,
    input logic [10:0] opc, input logic [1:0] aop,
    input logic asrc, br, ub, mr, mw, m2r, input logic [4:0] wr);
    logic [63:0] b, r;
    logic z, ps;
    b = asrc ? ext : rd2;
    r = 64'd0;
    if (aop == 2'b00) r = rd1 + b;
    else if (aop == 2'b01) r = b;
    else if (aop == 2'b10) begin
      if (opc == OP_ADD) r = rd1 + b;
      else if (opc == OP_SUB) r = rd1 - b;
      else if (opc == OP_AND) r = rd1 & b;
      else if (opc == OP_ORR) r = rd1 | b;
      else if (opc == OP_MUL) r = rd1 * b;
    end
    z  = (r == 64'd0);
    ps = ub | (br & z);
    return {r, pc + (ext << 2), rd2, z, ps, mr, mw, m2r, wr};
  endfunction

  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 1) == 0) return 64'($urandom_range(0, 3));
    return {$urandom, $urandom};
  endfunction

  // Scoreboard: every valid cycle must present the oldest expected record.
  always @(negedge clk) begin
    if (!reset) exp_q.delete();
    else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("sb_spurious_valid", 64'd1, 64'd0);
        else begin
          mon_e = exp_q[0];
          check("sb_result", bus.alu_result, mon_e[201:138]);
          check("sb_target", bus.branch_target, mon_e[137:74]);
          check("sb_store", bus.store_data, mon_e[73:10]);
          check("sb_flags", 64'({bus.zero, bus.pc_src, bus.mem_read_o, bus.mem_write_o,
                                bus.mem_to_reg_o, bus.write_reg_o}), 64'(mon_e[9:0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.read_data1, bus.read_data2, bus.ext_addr, bus.cur_pc,
                              bus.opcode, bus.alu_op, bus.alu_src, bus.branch,
                              bus.uncondbranch, bus.mem_read, bus.mem_write,
                              bus.mem_to_reg, bus.write_reg));
    end
  end

  // Driver tasks
  task automatic drive(input logic [63:0] rd1, rd2, ext, pc, input logic [10:0] opc,
                       input logic [1:0] aop, input logic asrc, br, ub);
    bus.read_data1   = rd1;
    bus.read_data2   = rd2;
    bus.ext_addr     = ext;
    bus.cur_pc       = pc;
    bus.opcode       = opc;
    bus.alu_op       = aop;
    bus.alu_src      = asrc;
    bus.branch       = br;
    bus.uncondbranch = ub;
    bus.mem_read     = 1'($urandom_range(0, 1));
    bus.mem_write    = 1'($urandom_range(0, 1));
    bus.mem_to_reg   = 1'($urandom_range(0, 1));
    bus.write_reg    = 5'($urandom_range(0, 31));
  endtask

  // Offers one instruction and returns #1 after the accepting edge.
  task automatic send(input logic [63:0] rd1, rd2, ext, pc, input logic [10:0] opc,
                      input logic [1:0] aop, input logic asrc, br, ub);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    drive(rd1, rd2, ext, pc, opc, aop, asrc, br, ub);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int low, first;
    bit seen, ok;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(64'd0, 64'd0, 64'd0, 64'd0, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.alu_result, 64'd0);
    check("rst_flags", 64'({bus.zero, bus.pc_src}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 64'(bus.in_ready), 64'd1);

    // ADD 20 + 10
    send(64'd20, 64'd10, 64'd0, 64'd0, OP_ADD, 2'b10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("add_result", bus.alu_result, 64'd30);
    check("add_zero", 64'(bus.zero), 64'd0);
    check("add_valid", 64'(bus.out_valid), 64'd1);

    // SUB 30 - 30, branch = 0
    send(64'd30, 64'd30, 64'd0, 64'd0, OP_SUB, 2'b10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("sub_result", bus.alu_result, 64'd0);
    check("sub_zero", 64'(bus.zero), 64'd1);
    check("sub_pc_src", 64'(bus.pc_src), 64'd0);

    // CBZ taken and not taken
    send(64'd99, 64'd0, 64'd3, 64'h10, OP_ADD, 2'b01, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("cbz_target", bus.branch_target, 64'h1C);
    check("cbz_taken", 64'(bus.pc_src), 64'd1);
    send(64'd99, 64'd5, 64'd3, 64'h10, OP_ADD, 2'b01, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("cbz_not_taken", 64'(bus.pc_src), 64'd0);

    // MUL 7 x 6 with fixed latency
    send(64'd7, 64'd6, 64'd0, 64'd0, OP_MUL, 2'b10, 1'b0, 1'b0, 1'b0);
    low = 0; first = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!bus.in_ready) low++;
      if (bus.out_valid) begin first = k; break; end
    end
    check("mul_ready_low", 64'(low), 64'd65);
    check("mul_valid_cycle", 64'(first), 64'd66);
    check("mul_result", bus.alu_result, 64'd42);

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, OP_MUL, 2'b10, 1'b0, 1'b0, 1'b0);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    check("mul2_done", 64'(ok), 64'd1);
    check("mul2_result", bus.alu_result, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset in the middle of a MUL
    send(64'd123, 64'd456, 64'd0, 64'd0, OP_MUL, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_result", bus.alu_result, 64'd0);
    check("mrst_target", bus.branch_target, 64'd0);
    check("mrst_flags", 64'({bus.zero, bus.pc_src, bus.in_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mrst_ready_after", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("mrst_no_valid", 64'(seen), 64'd0);

    // Backpressure on an ORR, then retire and load on the same edge
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(64'h1E, 64'h10, 64'd0, 64'd0, OP_ORR, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("bp_result", bus.alu_result, 64'h1E);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    drive(64'd1, 64'd2, 64'd0, 64'd0, OP_ADD, 2'b10, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_swap_valid", 64'(bus.out_valid), 64'd1);
    check("bp_swap_result", bus.alu_result, 64'd3);

    // Randomized traffic; inputs change every cycle whether accepted or not
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic [10:0] opc;
      logic [1:0] aop;
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      if (r == 0) opc = OP_MUL;
      else if (r <= 4) opc = OP_ADD;
      else if (r <= 8) opc = OP_SUB;
      else if (r <= 12) opc = OP_AND;
      else if (r <= 16) opc = OP_ORR;
      else opc = 11'($urandom_range(0, 2047));
      aop = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
      drive(rnd64(), rnd64(), rnd64(), rnd64(), opc, aop,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.in_valid = ($urandom_range(0, 9) < 6);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
